// File: rtl/pkt_tx_port_if.sv
// Ingress-side bundle for one switch port transmitter.
//
// Groups the descriptor handshake, the payload word stream, the switch
// backpressure input and the framed write bus that feeds the switch.
//   master : the transmitter (pkt_tx_port). It accepts descriptors and payload
//            words, observes full, and drives wr_sop/wr_eop/wr_vld/wr_data.
//   slave  : the environment. It supplies descriptors and payload words,
//            drives full, and receives the framed write bus.
interface pkt_tx_port_if #(
    parameter int PORT_NUB_TOTAL = 16,
    parameter int DATA_WIDTH     = 64,
    parameter int PRIO_WIDTH     = 3,
    parameter int LEN_WIDTH      = 8
);
    localparam int WIDTH_SEL = $clog2(PORT_NUB_TOTAL);

    logic                  desc_vld;
    logic                  desc_rdy;
    logic [WIDTH_SEL-1:0]  desc_dest;
    logic [PRIO_WIDTH-1:0] desc_prio;
    logic [LEN_WIDTH-1:0]  desc_len;

    logic                  pl_vld;
    logic                  pl_rdy;
    logic [DATA_WIDTH-1:0] pl_data;

    logic                  full;

    logic                  wr_sop;
    logic                  wr_eop;
    logic                  wr_vld;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        input  desc_vld, desc_dest, desc_prio, desc_len,
        input  pl_vld, pl_data,
        input  full,
        output desc_rdy, pl_rdy,
        output wr_sop, wr_eop, wr_vld, wr_data
    );

    modport slave (
        output desc_vld, desc_dest, desc_prio, desc_len,
        output pl_vld, pl_data,
        output full,
        input  desc_rdy, pl_rdy,
        input  wr_sop, wr_eop, wr_vld, wr_data
    );
endinterface

// File: rtl/pkt_tx_port.sv
// Per-port packet transmitter for the shared-cache switch ingress.
//
// Accepts a descriptor (dest, prio, len), then frames one packet onto the
// switch write bus: a sop pulse, a header word, len payload words, and an
// eop pulse. Every output is a flop, so each decision taken on a clock edge
// shows up on the bus in the following cycle.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   bus       pkt_tx_port_if.master: descriptor in, payload in, full in,
//             framed write bus out
//   busy      packet in progress, from the SOP state through the eop cycle
//   len_err   one-cycle pulse after a zero-length descriptor is rejected
//   pkt_cnt   packets completed, wraps silently
module pkt_tx_port #(
    parameter int PORT_NUB_TOTAL = 16,
    parameter int DATA_WIDTH     = 64,
    parameter int PRIO_WIDTH     = 3,
    parameter int LEN_WIDTH      = 8,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pkt_tx_port_if.master        bus,
    output logic                 busy,
    output logic                 len_err,
    output logic [CNT_WIDTH-1:0] pkt_cnt
);
    localparam int WIDTH_SEL = $clog2(PORT_NUB_TOTAL);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOP,
        ST_HEAD,
        ST_BODY,
        ST_EOP
    } state_t;

    state_t                state_q,   state_d;
    logic [WIDTH_SEL-1:0]  dest_q,    dest_d;
    logic [PRIO_WIDTH-1:0] prio_q,    prio_d;
    logic [LEN_WIDTH-1:0]  len_q,     len_d;
    logic [LEN_WIDTH-1:0]  remain_q,  remain_d;
    logic                  desc_rdy_q, desc_rdy_d;
    logic                  pl_rdy_q,  pl_rdy_d;
    logic                  wr_sop_q,  wr_sop_d;
    logic                  wr_eop_q,  wr_eop_d;
    logic                  wr_vld_q,  wr_vld_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_q,    busy_d;
    logic                  len_err_q, len_err_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [DATA_WIDTH-1:0] header;
    logic                  desc_accept;
    logic                  pl_accept;

    // Header word built from the latched descriptor; unused upper bits stay 0.
    always_comb begin
        header = '0;
        header[WIDTH_SEL-1:0]                       = dest_q;
        header[WIDTH_SEL +: PRIO_WIDTH]             = prio_q;
        header[WIDTH_SEL + PRIO_WIDTH +: LEN_WIDTH] = len_q;
    end

    // pl_rdy is registered, so a word offered in the cycle after full rises
    // is still taken; this is the single beat in flight the switch absorbs.
    assign desc_accept = bus.desc_vld && desc_rdy_q;
    assign pl_accept   = bus.pl_vld && pl_rdy_q;

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        prio_d    = prio_q;
        len_d     = len_q;
        remain_d  = remain_q;
        wr_sop_d  = 1'b0;
        wr_eop_d  = 1'b0;
        wr_vld_d  = 1'b0;
        wr_data_d = wr_data_q;
        len_err_d = 1'b0;
        pkt_cnt_d = pkt_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (desc_accept) begin
                    if (bus.desc_len != '0) begin
                        dest_d   = bus.desc_dest;
                        prio_d   = bus.desc_prio;
                        len_d    = bus.desc_len;
                        remain_d = bus.desc_len;
                        state_d  = ST_SOP;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            ST_SOP: begin
                if (!bus.full) begin
                    wr_sop_d = 1'b1;
                    state_d  = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (!bus.full) begin
                    wr_vld_d  = 1'b1;
                    wr_data_d = header;
                    state_d   = ST_BODY;
                end
            end
            ST_BODY: begin
                if (pl_accept) begin
                    wr_vld_d  = 1'b1;
                    wr_data_d = bus.pl_data;
                    remain_d  = remain_q - LEN_WIDTH'(1);
                    if (remain_q == LEN_WIDTH'(1)) begin
                        state_d = ST_EOP;
                    end
                end
            end
            ST_EOP: begin
                wr_eop_d  = 1'b1;
                pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake and status flops look at the state being entered so they
        // line up with the cycle in which that state is active. The eop beat
        // is issued on the way back to IDLE, so busy also covers it.
        desc_rdy_d = (state_d == ST_IDLE);
        pl_rdy_d   = (state_d == ST_BODY) && !bus.full;
        busy_d     = (state_d != ST_IDLE) || wr_eop_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dest_q     <= '0;
            prio_q     <= '0;
            len_q      <= '0;
            remain_q   <= '0;
            desc_rdy_q <= 1'b0;
            pl_rdy_q   <= 1'b0;
            wr_sop_q   <= 1'b0;
            wr_eop_q   <= 1'b0;
            wr_vld_q   <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            len_err_q  <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            prio_q     <= prio_d;
            len_q      <= len_d;
            remain_q   <= remain_d;
            desc_rdy_q <= desc_rdy_d;
            pl_rdy_q   <= pl_rdy_d;
            wr_sop_q   <= wr_sop_d;
            wr_eop_q   <= wr_eop_d;
            wr_vld_q   <= wr_vld_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            len_err_q  <= len_err_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign bus.desc_rdy = desc_rdy_q;
    assign bus.pl_rdy   = pl_rdy_q;
    assign bus.wr_sop   = wr_sop_q;
    assign bus.wr_eop   = wr_eop_q;
    assign bus.wr_vld   = wr_vld_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = busy_q;
    assign len_err      = len_err_q;
    assign pkt_cnt      = pkt_cnt_q;
endmodule

// File: tb/tb_pkt_tx_port.sv
// Self-checking bench for pkt_tx_port.
//
// The reference model describes each packet as a list of beats (header word
// built arithmetically from dest/prio/len, then the payload words in order)
// plus a running packet count. A monitor records every beat and framing
// pulse; after each packet the recorded stream is compared to the list.
// pkt_cnt is narrowed to 4 bits so the wrap is reached in a short run.
module tb_pkt_tx_port;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             busy;
    logic             len_err;
    logic [CNT_W-1:0] pkt_cnt;

    pkt_tx_port_if #(
        .PORT_NUB_TOTAL(16), .DATA_WIDTH(64), .PRIO_WIDTH(3), .LEN_WIDTH(8)
    ) bus ();

    pkt_tx_port #(
        .PORT_NUB_TOTAL(16), .DATA_WIDTH(64), .PRIO_WIDTH(3),
        .LEN_WIDTH(8), .CNT_WIDTH(CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .len_err (len_err),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int expCnt = 0;

    // Monitor state, updated once per cycle on the falling edge.
    int          cyc         = 0;
    int          sopCount    = 0;
    int          eopCount    = 0;
    int          lenErrCount = 0;
    int          sopCycle    = 0;
    int          eopCycle    = -10;
    int          violations  = 0;
    logic [63:0] obsBeats[$];
    int          beatCyc[$];

    // Record every beat and framing pulse; count framing-rule violations
    // (sop/eop overlap, vld during sop/eop, sop too close to the last eop,
    // busy low while a framing pulse is out).
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.wr_vld) begin
            obsBeats.push_back(bus.wr_data);
            beatCyc.push_back(cyc + 1);
        end
        if (bus.wr_sop) begin
            sopCount <= sopCount + 1;
            sopCycle <= cyc + 1;
            if (bus.wr_vld || bus.wr_eop || !busy || ((cyc + 1) - eopCycle < 2))
                violations <= violations + 1;
        end
        if (bus.wr_eop) begin
            eopCount <= eopCount + 1;
            eopCycle <= cyc + 1;
            if (bus.wr_vld || !busy)
                violations <= violations + 1;
        end
        if (len_err) lenErrCount <= lenErrCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] hdrWord(input int dest, input int prio, input int len);
        return 64'(dest) + 64'(prio) * 64'd16 + 64'(len) * 64'd128;
    endfunction

    // Offer one descriptor and hold it until desc_rdy takes it.
    task automatic offerDesc(input int dest, input int prio, input int len);
        int n;
        bus.desc_vld  = 1'b1;
        bus.desc_dest = 4'(dest);
        bus.desc_prio = 3'(prio);
        bus.desc_len  = 8'(len);
        n = 0;
        while (!bus.desc_rdy && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) checkOutput("desc_rdy_timeout", {63'd0, bus.desc_rdy}, 64'd1);
        tick();
        bus.desc_vld = 1'b0;
    endtask

    // Send one packet and check it against the model.
    // mode 0: no backpressure, payload always valid
    // mode 1: random full and random payload gaps
    // mode 2: full held through the first 4 edges in SOP
    // mode 3: full high for 2 cycles right after the 2nd payload word
    // base != 0 gives payload base+1, base+2, ...; otherwise random words.
    // stopBeats > 0 returns early once that many beats were seen.
    task automatic applyStimulus(input int dest, input int prio, input int len,
                                 input int mode, input logic [63:0] base,
                                 input int stopBeats);
        logic [63:0] expBeats[$];
        int idx, fullCnt, n, startEop, startSop, fallCyc;
        obsBeats.delete();
        beatCyc.delete();
        expBeats.push_back(hdrWord(dest, prio, len));
        for (int i = 0; i < len; i++)
            expBeats.push_back(base != 0 ? base + 64'(i + 1) : {$urandom(), $urandom()});
        startEop = eopCount;
        startSop = sopCount;
        fallCyc  = 0;
        bus.full = (mode == 2);
        offerDesc(dest, prio, len);
        idx = 0;
        fullCnt = 0;
        n = 0;
        while (eopCount == startEop && n < 3000 &&
               !(stopBeats > 0 && obsBeats.size() >= stopBeats)) begin
            tick();
            n++;
            case (mode)
                1: bus.full = ($urandom_range(0, 3) == 0);
                2: begin
                    bus.full = (n < 4);
                    if (n == 4) fallCyc = cyc;
                end
                3: begin
                    bus.full = (fullCnt > 0);
                    if (fullCnt > 0) fullCnt--;
                end
                default: bus.full = 1'b0;
            endcase
            if (idx < len) begin
                bus.pl_vld  = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.pl_data = expBeats[idx + 1];
                if (bus.pl_vld && bus.pl_rdy) begin
                    idx++;
                    if (mode == 3 && idx == 2) fullCnt = 2;
                end
            end else begin
                bus.pl_vld = 1'b0;
            end
        end
        bus.full   = 1'b0;
        bus.pl_vld = 1'b0;
        if (stopBeats > 0) return;

        expCnt++;
        checkOutput("eop_seen", 64'(eopCount - startEop), 64'd1);
        checkOutput("sop_count", 64'(sopCount - startSop), 64'd1);
        checkOutput("beat_count", 64'(obsBeats.size()), 64'(len + 1));
        for (int i = 0; i < len + 1; i++)
            if (i < obsBeats.size())
                checkOutput($sformatf("beat%0d", i), obsBeats[i], expBeats[i]);
        checkOutput("pkt_cnt", 64'(pkt_cnt), 64'(expCnt % (1 << CNT_W)));
        checkOutput("framing_rules", 64'(violations), 64'd0);
        if (mode == 0) begin
            checkOutput("sop_to_eop", 64'(eopCycle - sopCycle), 64'(len + 2));
            if (beatCyc.size() == len + 1) begin
                checkOutput("hdr_after_sop", 64'(beatCyc[0] - sopCycle), 64'd1);
                checkOutput("beats_back_to_back", 64'(beatCyc[len] - beatCyc[0]), 64'(len));
            end
        end
        if (mode == 2) checkOutput("sop_after_full_low", 64'(sopCycle - fallCyc), 64'd1);
        if (mode == 3) begin
            if (beatCyc.size() >= 5)
                checkOutput("bp_vld_gap", 64'(beatCyc[4] - beatCyc[3]), 64'd3);
            else
                checkOutput("bp_vld_gap_beats", 64'(beatCyc.size()), 64'd5);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int e0, s0, le0;
        rst           = 1'b1;
        bus.desc_vld  = 1'b0;
        bus.desc_dest = '0;
        bus.desc_prio = '0;
        bus.desc_len  = '0;
        bus.pl_vld    = 1'b0;
        bus.pl_data   = '0;
        bus.full      = 1'b0;
        tick();
        tick();
        checkOutput("reset_ctrl", {57'd0, bus.wr_sop, bus.wr_eop, bus.wr_vld, busy,
                                   len_err, bus.desc_rdy, bus.pl_rdy}, 64'd0);
        checkOutput("reset_data", bus.wr_data, 64'd0);
        checkOutput("reset_cnt", 64'(pkt_cnt), 64'd0);
        rst = 1'b0;
        tick();
        checkOutput("idle_desc_rdy", {63'd0, bus.desc_rdy}, 64'd1);
        checkOutput("idle_busy", {63'd0, busy}, 64'd0);

        // Basic packet: dest 5, prio 2, len 3, payload A1..A3.
        applyStimulus(5, 2, 3, 0, 64'hA0, 0);
        // Backpressure held while waiting to issue sop.
        applyStimulus(5, 2, 3, 2, 64'hB0, 0);
        // Backpressure pulse mid-body.
        applyStimulus(9, 7, 4, 3, 64'hC0, 0);

        // Zero-length descriptor is rejected with a single len_err pulse.
        obsBeats.delete();
        e0  = eopCount;
        s0  = sopCount;
        le0 = lenErrCount;
        offerDesc(3, 1, 0);
        checkOutput("len_err_pulse", {63'd0, len_err}, 64'd1);
        tick();
        checkOutput("len_err_clear", {63'd0, len_err}, 64'd0);
        repeat (4) tick();
        checkOutput("len_err_once", 64'(lenErrCount - le0), 64'd1);
        checkOutput("len_err_nothing_sent",
                    64'(obsBeats.size() + (sopCount - s0) + (eopCount - e0)), 64'd0);
        checkOutput("len_err_cnt", 64'(pkt_cnt), 64'(expCnt % (1 << CNT_W)));
        applyStimulus(2, 4, 2, 0, 64'hD0, 0);

        // Back-to-back descriptors.
        applyStimulus(1, 0, 1, 0, 64'hE0, 0);
        applyStimulus(15, 3, 2, 0, 64'hF0, 0);

        // Reset in the body after one of three words.
        applyStimulus(3, 1, 3, 0, 64'h10, 2);
        e0  = eopCount;
        rst = 1'b1;
        #1;
        checkOutput("midrst_ctrl", {57'd0, bus.wr_sop, bus.wr_eop, bus.wr_vld, busy,
                                    len_err, bus.desc_rdy, bus.pl_rdy}, 64'd0);
        checkOutput("midrst_data", bus.wr_data, 64'd0);
        checkOutput("midrst_cnt", 64'(pkt_cnt), 64'd0);
        repeat (3) tick();
        rst    = 1'b0;
        expCnt = 0;
        repeat (3) tick();
        checkOutput("midrst_no_eop", 64'(eopCount - e0), 64'd0);
        applyStimulus(6, 5, 1, 0, 64'h20, 0);

        // Randomized traffic, including a maximum-length packet; the packet
        // count wraps during this loop.
        for (int i = 0; i < 18; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            applyStimulus($urandom_range(0, 15), $urandom_range(0, 7),
                          (i == 0) ? 255 : $urandom_range(1, 12), 1, 64'd0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pkt_tx_port.md
Name: pkt_tx_port

Overview:
- Per-port packet transmitter that drives the switch ingress interface (wr_sop/wr_eop/wr_vld/wr_data) of one port of the shared-cache switch.
- Takes a descriptor (destination port, priority, payload length) and a payload word stream from a local source.
- Emits framed packets: header word first, then payload. Pauses on switch-side full backpressure.
- Instantiated once per port in traffic-generating testbenches and host-side ingress logic.

Parameters:
- PORT_NUB_TOTAL, 16, number of switch ports; WIDTH_SEL = $clog2(PORT_NUB_TOTAL).
- DATA_WIDTH, 64, ingress data word width.
- PRIO_WIDTH, 3, priority field width.
- LEN_WIDTH, 8, payload length field width, in words (max 255).
- CNT_WIDTH, 16, sent-packet counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- desc_vld  input  1  descriptor valid.
- desc_rdy  output  1  descriptor accepted when desc_vld & desc_rdy.
- desc_dest  input  WIDTH_SEL  destination port.
- desc_prio  input  PRIO_WIDTH  priority.
- desc_len  input  LEN_WIDTH  payload words, 1..2^LEN_WIDTH-1.
- pl_vld  input  1  payload word valid.
- pl_rdy  output  1  payload word consumed when pl_vld & pl_rdy.
- pl_data  input  DATA_WIDTH  payload word.
- full  input  1  switch cache full / backpressure.
- wr_sop  output  1  start-of-packet pulse.
- wr_eop  output  1  end-of-packet pulse.
- wr_vld  output  1  wr_data valid.
- wr_data  output  DATA_WIDTH  header or payload word.
- busy  output  1  packet in progress (FSM not IDLE).
- len_err  output  1  one-cycle pulse when a descriptor is rejected.
- pkt_cnt  output  CNT_WIDTH  packets completed, wraps at 2^CNT_WIDTH.

Behaviour:
- All outputs are registered.
  - During rst: wr_sop, wr_eop, wr_vld, busy, len_err, desc_rdy, pl_rdy = 0; wr_data = 0; pkt_cnt = 0; FSM = IDLE.
- Header word layout (wr_data):
  - [WIDTH_SEL-1:0] = dest.
  - [WIDTH_SEL+PRIO_WIDTH-1:WIDTH_SEL] = prio.
  - next LEN_WIDTH bits = len.
  - remaining upper bits = 0.
- FSM: IDLE -> SOP -> HEAD -> BODY -> EOP -> IDLE.
- IDLE:
  - desc_rdy = 1.
  - On accept with desc_len != 0: latch dest, prio, len; go to SOP.
  - On accept with desc_len == 0: pulse len_err next cycle, stay IDLE, emit nothing.
- SOP:
  - If full == 0 at the clock edge: next cycle wr_sop = 1, wr_vld = 0; go to HEAD.
  - If full == 1: wait; no sop is issued.
- HEAD:
  - If full == 0: next cycle wr_vld = 1 and wr_data = header; go to BODY.
  - If full == 1: wr_vld = 0; hold.
- BODY:
  - pl_rdy = ~full.
  - Each accepted payload word appears on wr_data with wr_vld = 1 exactly one cycle later; the remaining count decrements.
  - No accept (pl_vld = 0 or full = 1): wr_vld = 0 next cycle; wr_data holds its last value.
  - When the last word (count reaches 0) is accepted: go to EOP, pl_rdy = 0.
- EOP:
  - wr_eop = 1 for one cycle, wr_vld = 0.
  - pkt_cnt increments on the same edge.
  - Return to IDLE.
  - eop is never blocked by full.
- Spacing rules:
  - Minimum 1 idle cycle between wr_eop and the next wr_sop (desc_rdy is asserted only in IDLE).
  - wr_sop and wr_eop are never high in the same cycle.
  - wr_vld is never high in sop or eop cycles.
- Total vld beats per packet = desc_len + 1 (header included).
- Backpressure latency: full is sampled on the edge. One beat already registered may still appear the cycle after full rises; the switch tolerates one beat in flight.
- busy = 1 from the SOP state through the EOP cycle inclusive.
- Reset mid-packet:
  - Outputs clear immediately; no eop is emitted; the partial packet is abandoned.
  - The descriptor is lost; pkt_cnt = 0.
- pkt_cnt wraps from 2^CNT_WIDTH-1 to 0 without a flag.

Test Plan:
- Descriptor dest=5, prio=2, len=3; payload A1,A2,A3 continuous; full=0
  -> sop pulse; next cycle header 0x...3_2_5 (len=3, prio=2, dest=5 in their fields) with vld; then A1, A2, A3 on consecutive cycles with vld; then eop pulse; pkt_cnt=1; 6 cycles sop-to-eop.
- Same descriptor, full=1 held for 4 cycles while in SOP
  -> no sop until full falls; sop appears exactly 1 cycle after full samples 0.
- len=4, full pulses high for 2 cycles after the 2nd payload word
  -> wr_vld low for 2 cycles (at most 1 extra beat in flight); 5 vld beats total, order preserved; single eop.
- desc_len=0
  -> len_err pulses 1 cycle; no sop/vld/eop; pkt_cnt unchanged; the next valid descriptor is sent normally.
- Back-to-back descriptors (len=1, then len=2)
  -> eop, ≥1 idle cycle, then sop; pkt_cnt=2.
- rst asserted during BODY after 1 of 3 words
  -> all outputs 0 immediately, no eop, pkt_cnt=0; after release, a new len=1 packet is framed correctly.
